// File: rtl/nibble_serial_compare.sv
// Multi-nibble magnitude compare sequencer driving an external 4-bit comparator MSB-first.
// Optional two's-complement ordering via `define SIGNED_CMP_EN (adds signed_mode input).
module nibble_serial_compare #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_compare: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             sgn_q, sgn_d;
  logic             sgn_in;
  logic [3:0]       nib_a, nib_b;
  logic             top_nib;

  // cmp_l carries no decision weight; the equal/greater pair is sufficient.
  logic unused_cmp_l;
  assign unused_cmp_l = cmp_l;

`ifdef SIGNED_CMP_EN
  assign sgn_in = signed_mode;
`else
  assign sgn_in = 1'b0;
`endif

  // Flipping the sign bit of the top nibble on both sides maps two's-complement
  // order onto unsigned order; the remaining nibbles already compare correctly.
  assign top_nib = (idx_q == IDX_W'(NIB - 1));

  always_comb begin
    nib_a = 4'(a_q >> {idx_q, 2'b00});
    nib_b = 4'(b_q >> {idx_q, 2'b00});
    if (sgn_q && top_nib) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    sgn_d   = sgn_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a_in;
          b_d     = b_in;
          sgn_d   = sgn_in;
          idx_d   = IDX_W'(NIB - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cmp_e) begin
          if (idx_q == '0) begin
            eq_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          gt_d    = cmp_g;
          lt_d    = ~cmp_g;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      sgn_q   <= sgn_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign gt    = gt_q;
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign cmp_a = busy ? nib_a : 4'h0;
  assign cmp_b = busy ? nib_b : 4'h0;

endmodule

// File: tb/tb_nibble_serial_compare.sv
// Self-checking bench for nibble_serial_compare: directed cases plus randomized
// operands against an integer-level reference model; models the external comparator.
module tb_nibble_serial_compare;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         sm_r;
  logic         busy, done, gt, eq, lt;
  logic [3:0]   cmp_a, cmp_b;
  logic         cmp_g, cmp_e, cmp_l;
  logic         glitch, l_noise;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External comparator; glitch raises g on equal nibbles to exercise e-over-g priority.
  assign cmp_e = (cmp_a == cmp_b);
  assign cmp_g = (cmp_a > cmp_b) | (glitch & (cmp_a == cmp_b));
  assign cmp_l = l_noise;

  nibble_serial_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
`ifdef SIGNED_CMP_EN
    .signed_mode(sm_r),
`endif
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_l(cmp_l)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {gt,eq,lt} from integer comparison.
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
`ifdef SIGNED_CMP_EN
    if (sm) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
    end
`endif
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // Nibbles examined: down to the nibble holding the highest differing bit.
  function automatic int ref_k(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    int m;
    x = a ^ b;
    if (x == '0) return NIB;
    m = 0;
    for (int i = 0; i < W; i++) if (x[i]) m = i;
    return NIB - m / 4;
  endfunction

  function automatic logic [3:0] ref_nib(input logic [W-1:0] v, input int step, input logic sm);
    logic [3:0] n;
    n = 4'((v >> (4 * (NIB - 1 - step))) & 16'hF);
`ifdef SIGNED_CMP_EN
    if (sm && step == 0) n[3] = ~n[3];
`endif
    return n;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sm_r  = sm;
  endtask

  // Start must already be driven for (a,b); returns in the done cycle, #1 after the edge.
  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                             input bit interfere);
    logic [2:0] ef;
    int ek, busy_n;
    bit seen;
    ef = ref_flags(a, b, sm);
    ek = ref_k(a, b);
    busy_n = 0;
    seen = 0;
    for (int cyc = 1; cyc <= NIB + 3 && !seen; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      sm_r  = 1'($urandom);
      if (done) begin
        seen = 1;
        check_val("latency", cyc, ek + 1);
        check_val("busy_cycles", busy_n, ek);
        check_val("flags", {29'd0, gt, eq, lt}, {29'd0, ef});
        check_val("busy_in_done", {31'd0, busy}, 0);
        check_val("cmp_ab_in_done", {24'd0, cmp_a, cmp_b}, 0);
      end else if (busy) begin
        if (busy_n < NIB) begin
          check_val("cmp_a_nib", {28'd0, cmp_a}, {28'd0, ref_nib(a, busy_n, sm)});
          check_val("cmp_b_nib", {28'd0, cmp_b}, {28'd0, ref_nib(b, busy_n, sm)});
        end else begin
          check_val("run_overrun", busy_n, NIB - 1);
        end
        check_val("flags_cleared_in_run", {29'd0, gt, eq, lt}, 0);
        busy_n++;
        if (interfere) start = 1'b1;
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
  endtask

  task automatic idle_check(input logic [2:0] ef);
    @(posedge clk); #1;
    check_val("done_pulse_one_cycle", {31'd0, done}, 0);
    check_val("idle_busy", {31'd0, busy}, 0);
    check_val("idle_cmp_ab", {24'd0, cmp_a, cmp_b}, 0);
    check_val("flags_held", {29'd0, gt, eq, lt}, {29'd0, ef});
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    @(negedge clk);
    launch(a, b, sm);
    run_compare(a, b, sm, 1'b0);
    idle_check(ref_flags(a, b, sm));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit chain;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; sm_r = 1'b0;
    glitch = 1'b0; l_noise = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {24'd0, busy, done, gt, eq, lt, 3'd0},  0);
    check_val("reset_cmp_ab", {24'd0, cmp_a, cmp_b}, 0);
    @(negedge clk); rst_n = 1'b1;

    directed(16'h1234, 16'h1234, 1'b0);
    directed(16'h9000, 16'h1FFF, 1'b0);
    directed(16'h1230, 16'h1235, 1'b0);
    idle_check(3'b001);

    // Start re-pulsed while busy, then back-to-back start in the done cycle.
    @(negedge clk);
    launch(16'h0001, 16'h0002, 1'b0);
    run_compare(16'h0001, 16'h0002, 1'b0, 1'b1);
    launch(16'h0000, 16'h0000, 1'b0);
    run_compare(16'h0000, 16'h0000, 1'b0, 1'b0);
    idle_check(3'b010);

    // Reset in the second RUN cycle.
    @(negedge clk);
    launch(16'h1111, 16'h1111, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check_val("pre_reset_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_reset_state", {24'd0, busy, done, gt, eq, lt, 3'd0}, 0);
    check_val("mid_reset_cmp_ab", {24'd0, cmp_a, cmp_b}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("no_done_in_reset", {31'd0, done}, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    directed(16'h4321, 16'h4320, 1'b0);

    directed(16'h8000, 16'h0001, 1'b1);
    directed(16'h8000, 16'h0001, 1'b0);
    directed(16'h7FFF, 16'hFFFF, 1'b1);

    chain = 0;
    for (int it = 0; it < 60; it++) begin
      ra = W'($urandom);
      case ($urandom_range(2))
        0: rb = W'($urandom);
        1: rb = ra;
        default: begin
          rb = ra;
          rb[4 * $urandom_range(NIB - 1) +: 4] ^= 4'($urandom_range(15, 1));
        end
      endcase
      glitch  = 1'($urandom);
      l_noise = 1'($urandom);
      if (!chain) @(negedge clk);
      launch(ra, rb, 1'($urandom));
      run_compare(ra, rb, sm_r, 1'($urandom));
      chain = 1'($urandom);
      if (!chain) idle_check({gt, eq, lt} === 3'b100 || {gt, eq, lt} === 3'b010 ||
                             {gt, eq, lt} === 3'b001 ? {gt, eq, lt} : 3'b111);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
